// File: rtl/d_flip_flop_pkg.sv
// Shared register-width defaults for the d_flip_flop storage element.
package d_flip_flop_pkg;

    localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/d_flip_flop.sv
// Edge-triggered D register with asynchronous active-high reset.
// Build wider registers by setting WIDTH rather than instantiating arrays of 1-bit flops.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int unsigned      WIDTH       = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d;
    end

    // Reset is tested first, so it wins any edge on which it is still high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed self-checking bench for d_flip_flop: default 1-bit and 8-bit/A5 instances.
module tb_d_flip_flop;

    typedef struct {
        logic rst;
        logic d;
        logic exp_q;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_checks;
    int n_fail;

    vec_t vecs [12];

    d_flip_flop u_dff1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dff8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8)
    );

    // Period 8 ns, first rising edge at 4 ns.
    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        d1       = 1'b0;
        d8       = 8'h00;

        // {reset, d, q expected after the following rising edge}
        vecs[0]  = '{1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1};

        #1 reset = 1'b1;
        #1;
        check("reset_q1", {7'b0, q1}, 8'h00);
        check("reset_q8", q8, 8'hA5);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            d1    = vecs[i].d;
            tick();
            check($sformatf("vec%0d", i), {7'b0, q1}, {7'b0, vecs[i].exp_q});
        end

        // Async assert mid-cycle with q1 = 1: must clear before the next edge.
        @(negedge clk);
        d1 = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("async_q1", {7'b0, q1}, 8'h00);
        check("async_q8", q8, 8'hA5);
        tick();
        check("held_q1", {7'b0, q1}, 8'h00);

        // Release between edges with d = 0, then capture 1 one edge later.
        @(negedge clk);
        d1    = 1'b0;
        reset = 1'b0;
        #1;
        check("release_now", {7'b0, q1}, 8'h00);
        tick();
        check("release_edge", {7'b0, q1}, 8'h00);
        @(negedge clk);
        d1 = 1'b1;
        tick();
        check("release_capture", {7'b0, q1}, 8'h01);

        // 4 ns pulse that spans no rising edge.
        @(negedge clk);
        d1 = 1'b0;
        tick();
        check("pulse_pre", {7'b0, q1}, 8'h00);
        #1 d1 = 1'b1;
        #4 d1 = 1'b0;
        #1;
        check("pulse_mid", {7'b0, q1}, 8'h00);
        tick();
        check("pulse_post", {7'b0, q1}, 8'h00);

        // Falling edges do not capture.
        @(negedge clk);
        d1 = 1'b1;
        #1;
        check("negedge_hold", {7'b0, q1}, 8'h00);
        tick();
        check("negedge_then_pos", {7'b0, q1}, 8'h01);

        // 8-bit instance with non-zero reset value.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("w8_reset", q8, 8'hA5);
        @(negedge clk);
        reset = 1'b0;
        d8    = 8'h3C;
        #1;
        check("w8_release", q8, 8'hA5);
        tick();
        check("w8_cap3c", q8, 8'h3C);
        @(negedge clk);
        d8 = 8'hC3;
        #1;
        check("w8_hold", q8, 8'h3C);
        tick();
        check("w8_capc3", q8, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
